// File: rtl/stack_param_if.sv
// Command/response bundle for stack_param. The master drives the command
// side (COMMAND, INDEX, DIN); the slave returns registered read data,
// occupancy and status.
interface stack_param_if #(
  parameter int DATA_W = 4,
  parameter int IDX_W  = 3
);
  logic [1:0]        COMMAND;
  logic [IDX_W-1:0]  INDEX;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] DOUT;
  logic              DOUT_VALID;
  logic [IDX_W:0]    COUNT;
  logic              FULL;
  logic              EMPTY;
  logic              ERROR;

  modport master (
    output COMMAND, INDEX, DIN,
    input  DOUT, DOUT_VALID, COUNT, FULL, EMPTY, ERROR
  );

  modport slave (
    input  COMMAND, INDEX, DIN,
    output DOUT, DOUT_VALID, COUNT, FULL, EMPTY, ERROR
  );
endinterface

// File: rtl/stack_param.sv
// Parameterised LIFO stack built on a circular array. PTR is the next write
// slot, so the top of stack always sits at PTR-1 (mod DEPTH). With
// WRAP_MODE=1 a push onto a full stack overwrites the oldest entry, which is
// exactly the slot PTR points at once the array has gone round.
// All outputs are registered; reset is synchronous and clears the array too.
module stack_param #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 5,
  parameter int IDX_W     = 3,
  parameter int WRAP_MODE = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  stack_param_if.slave bus
);

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PUSH = 2'b01;
  localparam logic [1:0] CMD_POP  = 2'b10;
  localparam logic [1:0] CMD_GET  = 2'b11;

  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W+1:0] DEPTH_X  = (IDX_W + 2)'(DEPTH);
  localparam logic [IDX_W+1:0] ONE_X    = (IDX_W + 2)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  logic [IDX_W-1:0]  ptr_inc, ptr_dec, get_addr;
  logic [IDX_W+1:0]  get_sum, get_addr_x;
  logic              index_ok;

  // Pointer neighbours and GET address. Adding DEPTH before subtracting keeps
  // the sum non-negative whenever INDEX < COUNT, so one conditional subtract
  // completes the modulo.
  always_comb begin
    ptr_inc    = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    ptr_dec    = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;
    get_sum    = {2'b00, ptr_q} + DEPTH_X - ONE_X - {2'b00, bus.INDEX};
    get_addr_x = (get_sum >= DEPTH_X) ? get_sum - DEPTH_X : get_sum;
    get_addr   = IDX_W'(get_addr_x);
    index_ok   = ({1'b0, bus.INDEX} < count_q);
  end

  // Next-state for the array, pointer, occupancy and the one-cycle outputs.
  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    dout_d  = '0;
    valid_d = 1'b0;
    error_d = 1'b0;

    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      ptr_d   = '0;
      count_d = '0;
    end else begin
      case (bus.COMMAND)
        CMD_PUSH: begin
          if (count_q != CNT_MAX) begin
            mem_d[ptr_q] = bus.DIN;
            ptr_d        = ptr_inc;
            count_d      = count_q + 1'b1;
          end else if (WRAP_MODE != 0) begin
            mem_d[ptr_q] = bus.DIN;
            ptr_d        = ptr_inc;
          end else begin
            error_d = 1'b1;
          end
        end
        CMD_POP: begin
          if (count_q != '0) begin
            ptr_d   = ptr_dec;
            dout_d  = mem_q[ptr_dec];
            valid_d = 1'b1;
            count_d = count_q - 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        CMD_GET: begin
          if (index_ok) begin
            dout_d  = mem_q[get_addr];
            valid_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        CMD_NOP: ;
        default: ;
      endcase
    end

    full_d  = (count_d == CNT_MAX);
    empty_d = (count_d == '0);
  end

  // State and output registers; reset is folded into the next-state logic.
  always_ff @(posedge CLK) begin
    mem_q   <= mem_d;
    ptr_q   <= ptr_d;
    count_q <= count_d;
    dout_q  <= dout_d;
    valid_q <= valid_d;
    error_q <= error_d;
    full_q  <= full_d;
    empty_q <= empty_d;
  end

  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = valid_q;
  assign bus.COUNT      = count_q;
  assign bus.FULL       = full_q;
  assign bus.EMPTY      = empty_q;
  assign bus.ERROR      = error_q;

endmodule

// File: tb/tb_stack_param.sv
// Bench for stack_param: three instances (depth 5 overwrite, depth 5 reject,
// depth 8 overwrite). The driver issues one command per cycle to one instance
// and queues the hand-computed response; the monitor checks it after the edge.
module tb_stack_param;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] PSH = 2'b01;
  localparam logic [1:0] POP = 2'b10;
  localparam logic [1:0] GET = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_param_if #(.DATA_W(4), .IDX_W(3)) if0 ();
  stack_param_if #(.DATA_W(4), .IDX_W(3)) if1 ();
  stack_param_if #(.DATA_W(4), .IDX_W(3)) if2 ();

  stack_param #(.DATA_W(4), .DEPTH(5), .IDX_W(3), .WRAP_MODE(1))
    dut0 (.CLK(clk), .RESET(rst), .bus(if0));
  stack_param #(.DATA_W(4), .DEPTH(5), .IDX_W(3), .WRAP_MODE(0))
    dut1 (.CLK(clk), .RESET(rst), .bus(if1));
  stack_param #(.DATA_W(4), .DEPTH(8), .IDX_W(3), .WRAP_MODE(1))
    dut2 (.CLK(clk), .RESET(rst), .bus(if2));

  typedef struct {
    int         sel;
    string      name;
    logic [3:0] dout;
    logic       v;
    logic       e;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic drive(input int sel, input logic [1:0] c, input logic [2:0] idx,
                       input logic [3:0] d);
    if0.COMMAND = NOP; if0.INDEX = '0; if0.DIN = '0;
    if1.COMMAND = NOP; if1.INDEX = '0; if1.DIN = '0;
    if2.COMMAND = NOP; if2.INDEX = '0; if2.DIN = '0;
    case (sel)
      0: begin if0.COMMAND = c; if0.INDEX = idx; if0.DIN = d; end
      1: begin if1.COMMAND = c; if1.INDEX = idx; if1.DIN = d; end
      2: begin if2.COMMAND = c; if2.INDEX = idx; if2.DIN = d; end
      default: ;
    endcase
  endtask

  task automatic op(input int sel, input logic [1:0] c, input logic [2:0] idx,
                    input logic [3:0] d, input logic [3:0] xd, input logic xv,
                    input logic xe, input logic [3:0] xc, input string nm);
    exp_t x;
    @(negedge clk);
    rst = 1'b0;
    drive(sel, c, idx, d);
    x.sel = sel; x.name = nm; x.dout = xd; x.v = xv; x.e = xe; x.cnt = xc;
    sb.push_back(x);
  endtask

  task automatic rst_op(input int sel, input logic [1:0] c, input string nm);
    exp_t x;
    @(negedge clk);
    rst = 1'b1;
    drive(sel, c, 3'd0, 4'd0);
    x.sel = sel; x.name = nm; x.dout = 4'd0; x.v = 1'b0; x.e = 1'b0; x.cnt = 4'd0;
    sb.push_back(x);
  endtask

  // Monitor: one queued expectation per clock, checked just after the edge.
  exp_t       m;
  logic [3:0] a_dout, a_cnt;
  logic       a_v, a_e, a_full, a_empty, x_full, x_empty;
  int         m_depth;
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      m = sb.pop_front();
      case (m.sel)
        0: begin a_dout = if0.DOUT; a_v = if0.DOUT_VALID; a_e = if0.ERROR;
                 a_cnt = if0.COUNT; a_full = if0.FULL; a_empty = if0.EMPTY; end
        1: begin a_dout = if1.DOUT; a_v = if1.DOUT_VALID; a_e = if1.ERROR;
                 a_cnt = if1.COUNT; a_full = if1.FULL; a_empty = if1.EMPTY; end
        default: begin a_dout = if2.DOUT; a_v = if2.DOUT_VALID; a_e = if2.ERROR;
                 a_cnt = if2.COUNT; a_full = if2.FULL; a_empty = if2.EMPTY; end
      endcase
      m_depth = (m.sel == 2) ? 8 : 5;
      x_full  = (int'(m.cnt) == m_depth);
      x_empty = (m.cnt == 4'd0);
      n_cmp++;
      if (a_dout !== m.dout || a_v !== m.v || a_e !== m.e || a_cnt !== m.cnt ||
          a_full !== x_full || a_empty !== x_empty) begin
        n_bad++;
        $display("FAIL %s (dut%0d): got dout=%h v=%b err=%b cnt=%0d full=%b empty=%b; want dout=%h v=%b err=%b cnt=%0d full=%b empty=%b",
                 m.name, m.sel, a_dout, a_v, a_e, a_cnt, a_full, a_empty,
                 m.dout, m.v, m.e, m.cnt, x_full, x_empty);
      end
    end
  end

  initial begin
    drive(0, NOP, 3'd0, 4'd0);

    rst_op(0, NOP, "reset_dut0");
    rst_op(1, NOP, "reset_dut1");
    rst_op(2, NOP, "reset_dut2");

    // Basic LIFO order.
    op(0, PSH, 0, 4'd1, 4'd0, 0, 0, 4'd1, "push1");
    op(0, PSH, 0, 4'd2, 4'd0, 0, 0, 4'd2, "push2");
    op(0, PSH, 0, 4'd3, 4'd0, 0, 0, 4'd3, "push3");
    op(0, POP, 0, 4'd0, 4'd3, 1, 0, 4'd2, "pop_3");
    op(0, POP, 0, 4'd0, 4'd2, 1, 0, 4'd1, "pop_2");
    op(0, POP, 0, 4'd0, 4'd1, 1, 0, 4'd0, "pop_1");

    // Empty-stack and out-of-range accesses.
    op(0, POP, 0, 4'd0, 4'd0, 0, 1, 4'd0, "pop_empty");
    op(0, PSH, 0, 4'd9, 4'd0, 0, 0, 4'd1, "push9");
    op(0, GET, 1, 4'd0, 4'd0, 0, 1, 4'd1, "get_idx_eq_count");
    op(0, GET, 0, 4'd0, 4'd9, 1, 0, 4'd1, "get_top_9");
    op(0, GET, 7, 4'd0, 4'd0, 0, 1, 4'd1, "get_idx_ge_depth");
    op(0, NOP, 0, 4'd5, 4'd0, 0, 0, 4'd1, "nop_holds");
    op(0, POP, 0, 4'd0, 4'd9, 1, 0, 4'd0, "pop_9");

    // Overwrite-oldest policy: 1..7 into depth 5 keeps 3..7.
    for (int i = 1; i <= 7; i++)
      op(0, PSH, 0, 4'(i), 4'd0, 0, 0, 4'((i < 5) ? i : 5), "wrap_push");
    for (int i = 0; i <= 4; i++)
      op(0, GET, 3'(i), 4'd0, 4'(7 - i), 1, 0, 4'd5, "wrap_get");

    // Reject policy.
    for (int i = 1; i <= 5; i++)
      op(1, PSH, 0, 4'(i), 4'd0, 0, 0, 4'(i), "rej_push");
    op(1, PSH, 0, 4'd6, 4'd0, 0, 1, 4'd5, "rej_push_full");
    op(1, POP, 0, 4'd0, 4'd5, 1, 0, 4'd4, "rej_pop_5");
    op(1, GET, 0, 4'd0, 4'd4, 1, 0, 4'd4, "rej_get_4");

    // Depth 8: pointer wraps in both directions.
    for (int i = 1; i <= 8; i++)
      op(2, PSH, 0, 4'(i), 4'd0, 0, 0, 4'(i), "d8_fill");
    op(2, POP, 0, 4'd0,  4'd8,  1, 0, 4'd7, "d8_pop8");
    op(2, POP, 0, 4'd0,  4'd7,  1, 0, 4'd6, "d8_pop7");
    op(2, POP, 0, 4'd0,  4'd6,  1, 0, 4'd5, "d8_pop6");
    op(2, PSH, 0, 4'd10, 4'd0,  0, 0, 4'd6, "d8_push10");
    op(2, PSH, 0, 4'd11, 4'd0,  0, 0, 4'd7, "d8_push11");
    op(2, PSH, 0, 4'd12, 4'd0,  0, 0, 4'd8, "d8_push12");
    op(2, GET, 7, 4'd0,  4'd1,  1, 0, 4'd8, "d8_get7_first");
    op(2, GET, 0, 4'd0,  4'd12, 1, 0, 4'd8, "d8_get0");
    op(2, POP, 0, 4'd0,  4'd12, 1, 0, 4'd7, "d8_pop_ptr0_wrap");
    op(2, PSH, 0, 4'd12, 4'd0,  0, 0, 4'd8, "d8_repush12");
    op(2, PSH, 0, 4'd13, 4'd0,  0, 0, 4'd8, "d8_overwrite13");
    op(2, GET, 7, 4'd0,  4'd2,  1, 0, 4'd8, "d8_get7_after_ow");
    op(2, GET, 0, 4'd0,  4'd13, 1, 0, 4'd8, "d8_get0_13");

    // Reset mid-sequence with a POP pending: the POP is discarded.
    op(0, PSH, 0, 4'd4, 4'd0, 0, 0, 4'd5, "pre_rst_push4");
    op(0, PSH, 0, 4'd5, 4'd0, 0, 0, 4'd5, "pre_rst_push5");
    rst_op(0, POP, "reset_with_pop");
    op(0, POP, 0, 4'd0, 4'd0, 0, 1, 4'd0, "pop_after_reset");
    op(1, POP, 0, 4'd0, 4'd0, 0, 1, 4'd0, "dut1_pop_after_reset");
    op(2, GET, 0, 4'd0, 4'd0, 0, 1, 4'd0, "dut2_get_after_reset");

    @(negedge clk);
    drive(0, NOP, 3'd0, 4'd0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d expectations pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_param.md
STACK_PARAM -- requirements
Module: stack_param

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the element width in bits.
REQ-002 Parameter DEPTH, default 5, SHALL set the element count; legal range 2..256; non-power-of-two SHALL be supported.
REQ-003 Parameter IDX_W, default 3, SHALL set the INDEX width; ceil(log2(DEPTH)) <= IDX_W <= 8.
REQ-004 Parameter WRAP_MODE, default 1, SHALL select overflow policy: 1 = overwrite oldest, 0 = reject.
REQ-005 CLK  input  1  SHALL be the clock; all state updates on rising edge only.
REQ-006 RESET  input  1  SHALL be the reset: synchronous, active-high.
REQ-007 COMMAND  input  2  SHALL encode the operation: 00 NOP, 01 PUSH, 10 POP, 11 GET.
REQ-008 INDEX  input  IDX_W  SHALL give the GET depth; 0 = top of stack.
REQ-009 DIN  input  DATA_W  SHALL carry PUSH data.
REQ-010 DOUT  output  DATA_W  SHALL be registered read data; 0 whenever DOUT_VALID is low.
REQ-011 DOUT_VALID  output  1  SHALL pulse high for one cycle when DOUT carries a POP/GET result.
REQ-012 COUNT  output  IDX_W+1  SHALL report occupancy, 0..DEPTH.
REQ-013 FULL / EMPTY  output  1 each  SHALL equal (COUNT==DEPTH) / (COUNT==0), registered.
REQ-014 ERROR  output  1  SHALL pulse high for one cycle on a rejected command.

Function
REQ-015 Command sampled at rising edge; DOUT, DOUT_VALID, ERROR, COUNT, FULL, EMPTY SHALL update on that same edge (1-cycle latency); no combinational input-to-output path.
REQ-016 Storage SHALL be a circular array addressed by write pointer PTR (0..DEPTH-1); increment from DEPTH-1 wraps to 0; decrement from 0 wraps to DEPTH-1.
REQ-017 NOP: no state change; DOUT_VALID=0, ERROR=0.
REQ-018 PUSH, COUNT<DEPTH: mem[PTR]<=DIN, PTR advances, COUNT+1.
REQ-019 PUSH, FULL, WRAP_MODE=1: mem[PTR]<=DIN (overwrites oldest), PTR advances, COUNT stays DEPTH, ERROR=0.
REQ-020 PUSH, FULL, WRAP_MODE=0: no write, no pointer/count change, ERROR=1.
REQ-021 POP, COUNT>0: PTR decrements, DOUT<=mem[new PTR], DOUT_VALID=1, COUNT-1.
REQ-022 POP, EMPTY (either mode): no state change, DOUT=0, DOUT_VALID=0, ERROR=1.
REQ-023 GET, INDEX<COUNT: DOUT<=mem[(PTR-1-INDEX) mod DEPTH], DOUT_VALID=1; PTR/COUNT unchanged; modulo SHALL use IDX_W+2-bit arithmetic without truncation.
REQ-024 GET, INDEX>=COUNT (includes INDEX>=DEPTH): DOUT=0, DOUT_VALID=0, ERROR=1.
REQ-025 Only one command per cycle; back-to-back commands on consecutive cycles SHALL each be honoured, with each POP/GET seeing all earlier PUSHes.
REQ-026 DOUT_VALID and ERROR SHALL never be high in the same cycle.

Reset
REQ-027 RESET high at rising edge SHALL override COMMAND: PTR=0, COUNT=0, all memory entries 0, DOUT=0, DOUT_VALID=0, ERROR=0, EMPTY=1, FULL=0.
REQ-028 Reset asserted mid-sequence SHALL discard the in-flight command; the first command after RESET deasserts SHALL see an empty stack.
REQ-029 Outputs SHALL be X-free from the first edge after reset.

Verification (DATA_W=4, DEPTH=5)
REQ-030 PUSH 1,2,3 then POP x3 -> DOUT 3,2,1 with DOUT_VALID on each; COUNT 3->0; EMPTY=1 at end.
REQ-031 WRAP_MODE=1: PUSH 1..7 then GET idx 0..4 -> 7,6,5,4,3; COUNT=5, FULL=1, ERROR never set.
REQ-032 WRAP_MODE=0: PUSH 1..6 -> 6th PUSH ERROR=1, COUNT=5; POP -> 5.
REQ-033 Empty stack: POP -> ERROR=1, DOUT_VALID=0; PUSH 9, GET idx 1 -> ERROR=1; GET idx 0 -> 9.
REQ-034 PUSH 4,5; RESET with COMMAND=POP; then POP -> ERROR=1, COUNT=0, DOUT=0.
REQ-035 DEPTH=8, IDX_W=3: fill, POP x3, PUSH x3 across pointer wrap, GET idx 7 -> first pushed value.
